ig_seq_ctrl: RTL and testbench

IG_SEQ_CTRL -- requirements
Module: ig_seq_ctrl

---
 rtl/ig_pkg.sv | 26 ++
 rtl/ig_line_buf.sv | 32 +++
 rtl/ig_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_ig_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ig_pkg.sv
// Shared constants, state encoding and the pixel-difference helper for the
// image gradient sequencer.
package ig_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int ADDR_W    = 16;
    localparam int PIX_W     = 8;
    localparam int GRAD_W    = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // 9-bit signed a-b, sign-extended to the gradient field; cannot wrap.
    function automatic logic [GRAD_W-1:0] pix_diff(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
        logic [PIX_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return {{(GRAD_W-PIX_W-1){d[PIX_W]}}, d};
    endfunction

endpackage

// File: rtl/ig_line_buf.sv
// One-row pixel store: synchronous read, one write per cycle, a read and a
// write to the same index in one cycle returns the old value.
module ig_line_buf
    import ig_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [PIX_W-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [PIX_W-1:0] wr_data_i
);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ig_seq_ctrl.sv
// Streams a raster image in, emits forward-difference gradients {Gx,Gy} for
// every pixel in ascending address order using a single line buffer.
//   state    | meaning
//   ST_IDLE  | waiting for start after reset
//   ST_READ  | issuing image reads, one address per cycle
//   ST_FLUSH | pipeline drain plus last row emitted from the line buffer
//   ST_DONE  | frame complete, done held until the next start
module ig_seq_ctrl
    import ig_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  img_rd_o,
    output logic [ADDR_W-1:0]     img_addr_o,
    input  logic [PIX_W-1:0]      img_di_i,
    output logic                  grad_wr_o,
    output logic [ADDR_W-1:0]     grad_addr_o,
    output logic [2*GRAD_W-1:0]   grad_do_o
);

    localparam int IDX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ADDR_W-1:0] LAST_X    = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_Y    = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] VIRT_Y    = ADDR_W'(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]   ix_q, iy_q, img_addr_q;
    logic [ADDR_W-1:0]   ax_q, ay_q, wr_cnt_q, grad_addr_q;
    logic                av_q, grad_wr_q;
    logic [PIX_W-1:0]    top_q, rd_data;
    logic [2*GRAD_W-1:0] grad_do_q;
    logic [GRAD_W-1:0]   gx, gy;
    logic                accept, iss_act, emit;
    logic [IDX_W-1:0]    rd_idx;

    assign accept  = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
    // Issue stage keeps running through one virtual row (y == IMG_H) so the
    // last real row is read back out of the line buffer with Gy forced to 0.
    assign iss_act = (state_q == ST_READ) || (state_q == ST_FLUSH && iy_q == VIRT_Y);
    assign emit    = av_q && (ay_q != '0);
    assign rd_idx  = (ix_q == LAST_X) ? '0 : IDX_W'(ix_q + ONE);

    // rd_data is p(x+1,y-1) and top_q is p(x,y-1) while p(x,y) is on img_di.
    assign gx = (ax_q == LAST_X) ? '0 : pix_diff(rd_data, top_q);
    assign gy = (ay_q == VIRT_Y) ? '0 : pix_diff(img_di_i, top_q);

    ig_line_buf #(.DEPTH(IMG_W), .IDX_W(IDX_W)) u_line_buf (
        .clk_i     (clk_i),
        .rd_en_i   (iss_act),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .wr_en_i   (av_q && (ay_q != VIRT_Y)),
        .wr_idx_i  (IDX_W'(ax_q)),
        .wr_data_i (img_di_i)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_i) state_d = ST_READ;
            ST_READ:          if (ix_q == LAST_X && iy_q == LAST_Y) state_d = ST_FLUSH;
            ST_FLUSH:         if (grad_wr_q && grad_addr_q == LAST_ADDR) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            ix_q        <= '0;
            iy_q        <= '0;
            img_addr_q  <= '0;
            ax_q        <= '0;
            ay_q        <= '0;
            av_q        <= 1'b0;
            top_q       <= '0;
            wr_cnt_q    <= '0;
            grad_wr_q   <= 1'b0;
            grad_addr_q <= '0;
            grad_do_q   <= '0;
        end else begin
            state_q   <= state_d;
            av_q      <= iss_act;
            ax_q      <= ix_q;
            ay_q      <= iy_q;
            top_q     <= rd_data;
            grad_wr_q <= emit;
            if (emit) begin
                grad_addr_q <= wr_cnt_q;
                wr_cnt_q    <= wr_cnt_q + ONE;
                grad_do_q   <= {gx, gy};
            end
            if (accept) begin
                ix_q        <= '0;
                iy_q        <= '0;
                img_addr_q  <= '0;
                wr_cnt_q    <= '0;
                grad_addr_q <= '0;
            end else if (iss_act) begin
                if (ix_q == LAST_X) begin
                    ix_q <= '0;
                    iy_q <= iy_q + ONE;
                end else begin
                    ix_q <= ix_q + ONE;
                end
                if (state_q == ST_READ && img_addr_q != LAST_ADDR) begin
                    img_addr_q <= img_addr_q + ONE;
                end
            end
        end
    end

    assign busy_o      = (state_q == ST_READ) || (state_q == ST_FLUSH);
    assign done_o      = (state_q == ST_DONE);
    assign img_rd_o    = (state_q == ST_READ);
    assign img_addr_o  = img_addr_q;
    assign grad_wr_o   = grad_wr_q;
    assign grad_addr_o = grad_addr_q;
    assign grad_do_o   = grad_do_q;

endmodule

// File: tb/tb_ig_seq_ctrl.sv
// Self-checking bench for ig_seq_ctrl on a reduced 8x6 image: a frame model
// computes every gradient from the pixel array and a monitor checks each write.
module tb_ig_seq_ctrl;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  img_di_i = 8'h00;
    logic        busy_o, done_o, img_rd_o, grad_wr_o;
    logic [15:0] img_addr_o, grad_addr_o;
    logic [19:0] grad_do_o;

    always #5 clk_i = ~clk_i;

    ig_seq_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .img_rd_o    (img_rd_o),
        .img_addr_o  (img_addr_o),
        .img_di_i    (img_di_i),
        .grad_wr_o   (grad_wr_o),
        .grad_addr_o (grad_addr_o),
        .grad_do_o   (grad_do_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_wr = 0;
    int          exp_rd = 0;
    int          wr_count = 0;
    int          done_rises = 0;
    logic        done_prev = 1'b0;
    logic [7:0]  pix [N];
    logic [19:0] got [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [19:0] exp_grad(input int a);
        int x, y, gx, gy;
        x  = a % W;
        y  = a / W;
        gx = (x == W - 1) ? 0 : int'(pix[a + 1]) - int'(pix[a]);
        gy = (y == H - 1) ? 0 : int'(pix[a + W]) - int'(pix[a]);
        return {10'(gx), 10'(gy)};
    endfunction

    task automatic set_pattern(input int kind);
        for (int a = 0; a < N; a++) begin
            int x, y;
            x = a % W;
            y = a / W;
            case (kind)
                0:       pix[a] = 8'h80;
                1:       pix[a] = 8'(x);
                2:       pix[a] = 8'(y);
                3:       pix[a] = (a == 0) ? 8'hFF : 8'h00;
                5:       pix[a] = ((x + y) % 2 == 1) ? 8'hFF : 8'h00;
                default: pix[a] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Image memory: data for the address strobed this cycle appears next cycle.
    always @(posedge clk_i) begin
        logic        r;
        logic [15:0] a;
        r = img_rd_o;
        a = img_addr_o;
        #1;
        img_di_i = (r && int'(a) < N) ? pix[a] : 8'h00;
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (grad_wr_o) begin
                check("grad_addr", 32'(grad_addr_o), 32'(exp_wr));
                if (exp_wr < N) check("grad_do", 32'(grad_do_o), 32'(exp_grad(exp_wr)));
                if (int'(grad_addr_o) < N) got[grad_addr_o] = grad_do_o;
                exp_wr++;
                wr_count++;
            end
            if (img_rd_o) begin
                check("img_addr", 32'(img_addr_o), 32'(exp_rd));
                exp_rd++;
            end
            if (done_o) check("done_quiet", 32'({busy_o, img_rd_o, grad_wr_o}), 32'(0));
            if (done_o && !done_prev) done_rises++;
            done_prev = done_o;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_ctl"},       32'({busy_o, done_o, img_rd_o, grad_wr_o}), 32'(0));
        check({tag, "_img_addr"},  32'(img_addr_o), 32'(0));
        check({tag, "_grad_addr"}, 32'(grad_addr_o), 32'(0));
        check({tag, "_grad_do"},   32'(grad_do_o), 32'(0));
    endtask

    // mode 0: plain frame; 1: extra start pulses in READ and FLUSH;
    // 2: reset asserted once 10 writes have been seen.
    task automatic run_frame(input int mode);
        int lat;
        bit fl_pulsed;
        exp_wr = 0;
        exp_rd = 0;
        wr_count = 0;
        done_rises = 0;
        fl_pulsed = 0;
        for (int i = 0; i < N; i++) got[i] = 20'hFFFFF;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        lat = 0;
        forever begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            lat++;
            if (mode == 1 && lat == 5) start_i = 1'b1;
            if (mode == 1 && !fl_pulsed && busy_o && !img_rd_o) begin
                start_i = 1'b1;
                fl_pulsed = 1;
            end
            if (mode == 2 && wr_count >= 10) begin
                rst_n_i = 1'b0;
                #1;
                check("abort_writes", 32'(wr_count), 32'(10));
                check_reset("abort");
                return;
            end
            if (done_o) break;
            if (lat > 4 * N + 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
                return;
            end
        end
        n_checks++;
        if (lat > N + W + 4) begin
            n_errors++;
            $display("FAIL latency: got %0d cycles, expected at most %0d", lat, N + W + 4);
        end
        check("writes", 32'(wr_count), 32'(N));
        check("reads", 32'(exp_rd), 32'(N));
        repeat (3) @(posedge clk_i);
        #1;
        check("done_hold", 32'(done_o), 32'(1));
        check("no_extra_writes", 32'(wr_count), 32'(N));
        check("done_rises", 32'(done_rises), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset("por");
        rst_n_i = 1'b1;

        set_pattern(0);
        run_frame(0);
        check("const_lit0", 32'(got[0]), 32'h00000);
        check("const_litN", 32'(got[N-1]), 32'h00000);

        set_pattern(1);
        run_frame(0);
        check("hramp_x0", 32'(got[0]), 32'h00400);
        check("hramp_xlast", 32'(got[W-1]), 32'h00000);

        set_pattern(2);
        run_frame(0);
        check("vramp_y0", 32'(got[0]), 32'h00001);
        check("vramp_ylast", 32'(got[(H-1)*W]), 32'h00000);
        check("vramp_corner", 32'(got[W*(H-1)-1]), 32'h00001);

        set_pattern(3);
        run_frame(0);
        check("impulse_0", 32'(got[0]), 32'hC0701);
        check("impulse_1", 32'(got[1]), 32'h00000);
        check("impulse_W", 32'(got[W]), 32'h00000);

        set_pattern(5);
        run_frame(0);
        check("checker_0", 32'(got[0]), 32'h3FCFF);
        check("checker_1", 32'(got[1]), 32'h00701 | 32'hC0000);

        set_pattern(4);
        run_frame(1);

        set_pattern(4);
        run_frame(2);
        repeat (2) @(posedge clk_i);
        #1;
        check_reset("in_reset");
        rst_n_i = 1'b1;
        done_prev = 1'b0;

        set_pattern(4);
        run_frame(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
